rom_arbiter: RTL and testbench

Shares the single instruction ROM line-read port between two requesters: the Icache refill path (req 0) and the Dcache/load path for constant data held in ROM (req 1). It arbitrates, latches the winning address, and sequences the ROM's one-cycle-latency request/ready protocol. It returns the 128-bit line to the winner. It sits between both caches and the ROM, and its ROM-side ports connect directly to the ROM's Icache_addr_i, Icache_valid_req_i, mem_data_o and mem_ready_o.

---
 rtl/rom_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 30 +++
 rtl/rom_arbiter.sv | 127 ++++++++++++
 tb/tb_rom_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared constants for the two-requester ROM line-read arbiter.
// FSM encoding, requester ids and line-alignment helper.
package rom_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic REQ_IC = 1'b0;
    localparam logic REQ_DC = 1'b1;

    localparam int LINE_OFFSET_BITS = 4;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input picker: round-robin with a pointer register, or fixed priority
// (req 0 first). Grant is one-hot, or zero when nothing is requested.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       fixed,
    output logic [1:0] grant
);

    // ptr = 1 means req 1 is favoured on the next tie
    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11)
            grant = (fixed || !ptr) ? 2'b01 : 2'b10;
        else
            grant = req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (advance && (grant != 2'b00))
            ptr <= grant[0];
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the ROM line-read port between Icache refill (req 0) and Dcache
// constant loads (req 1); all outputs registered, one line per 4 cycles.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned ROM_BYTES  = 4096,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  ic_addr_i,
    input  logic         ic_valid_req_i,
    output logic [127:0] ic_data_o,
    output logic         ic_ready_o,
    output logic         ic_err_o,
    input  logic [31:0]  dc_addr_i,
    input  logic         dc_valid_req_i,
    output logic [127:0] dc_data_o,
    output logic         dc_ready_o,
    output logic         dc_err_o,
    output logic [31:0]  rom_addr_o,
    output logic         rom_valid_req_o,
    input  logic [127:0] rom_data_i,
    input  logic         rom_ready_i
);

    localparam logic [31:0] ROM_LIMIT = 32'(ROM_BYTES);

    logic [1:0]  state;
    logic        win_id;
    logic [31:0] lat_addr;

    logic [1:0]  grant;
    logic        pick;
    logic [31:0] pick_addr;
    logic        pick_in_range;
    logic        lat_in_range;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({dc_valid_req_i, ic_valid_req_i}),
        .advance (state == IDLE),
        .fixed   (FIXED_PRIO != 0),
        .grant   (grant)
    );

    // Full 32-bit compare so high addresses never alias into the ROM.
    always_comb begin
        pick          = grant[1] ? REQ_DC : REQ_IC;
        pick_addr     = line_align(pick ? dc_addr_i : ic_addr_i);
        pick_in_range = (pick_addr < ROM_LIMIT);
        lat_in_range  = (lat_addr < ROM_LIMIT);
    end

    // The ROM request register is loaded on the IDLE->REQ edge so that it is
    // visible for exactly the REQ cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            win_id          <= REQ_IC;
            lat_addr        <= '0;
            rom_addr_o      <= '0;
            rom_valid_req_o <= 1'b0;
            ic_data_o       <= '0;
            ic_ready_o      <= 1'b0;
            ic_err_o        <= 1'b0;
            dc_data_o       <= '0;
            dc_ready_o      <= 1'b0;
            dc_err_o        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        win_id   <= pick;
                        lat_addr <= pick_addr;
                        state    <= REQ;
                        if (pick_in_range) begin
                            rom_valid_req_o <= 1'b1;
                            rom_addr_o      <= pick_addr;
                        end
                    end
                end
                REQ: begin
                    rom_valid_req_o <= 1'b0;
                    rom_addr_o      <= '0;
                    if (lat_in_range) begin
                        state <= WAIT;
                    end else begin
                        state <= RESP;
                        if (win_id == REQ_DC) begin
                            dc_ready_o <= 1'b1;
                            dc_err_o   <= 1'b1;
                        end else begin
                            ic_ready_o <= 1'b1;
                            ic_err_o   <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (rom_ready_i) begin
                        state <= RESP;
                        if (win_id == REQ_DC) begin
                            dc_ready_o <= 1'b1;
                            dc_data_o  <= rom_data_i;
                        end else begin
                            ic_ready_o <= 1'b1;
                            ic_data_o  <= rom_data_i;
                        end
                    end
                end
                RESP: begin
                    // Lets a requester's still-high valid fall before IDLE re-arbitrates.
                    ic_ready_o <= 1'b0;
                    ic_err_o   <= 1'b0;
                    ic_data_o  <= '0;
                    dc_ready_o <= 1'b0;
                    dc_err_o   <= 1'b0;
                    dc_data_o  <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: a round-robin instance and a fixed-priority
// instance, each in front of a behavioural ROM with programmable extra latency.
module tb_rom_arbiter;
    import rom_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // round-robin instance
    logic [31:0]  ic_addr = '0, dc_addr = '0;
    logic         ic_valid = 1'b0, dc_valid = 1'b0;
    logic [127:0] ic_data, dc_data;
    logic         ic_ready, dc_ready, ic_err, dc_err;
    logic [31:0]  rom_addr;
    logic         rom_valid;
    logic [127:0] rom_data = '0;
    logic         rom_ready = 1'b0;

    // fixed-priority instance
    logic [31:0]  f_ic_addr = '0, f_dc_addr = '0;
    logic         f_ic_valid = 1'b0, f_dc_valid = 1'b0;
    logic [127:0] f_ic_data, f_dc_data;
    logic         f_ic_ready, f_dc_ready, f_ic_err, f_dc_err;
    logic [31:0]  f_rom_addr;
    logic         f_rom_valid;
    logic [127:0] f_rom_data = '0;
    logic         f_rom_ready = 1'b0;

    rom_arbiter #(.ROM_BYTES(4096), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_addr_i(ic_addr), .ic_valid_req_i(ic_valid),
        .ic_data_o(ic_data), .ic_ready_o(ic_ready), .ic_err_o(ic_err),
        .dc_addr_i(dc_addr), .dc_valid_req_i(dc_valid),
        .dc_data_o(dc_data), .dc_ready_o(dc_ready), .dc_err_o(dc_err),
        .rom_addr_o(rom_addr), .rom_valid_req_o(rom_valid),
        .rom_data_i(rom_data), .rom_ready_i(rom_ready)
    );

    rom_arbiter #(.ROM_BYTES(4096), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .ic_addr_i(f_ic_addr), .ic_valid_req_i(f_ic_valid),
        .ic_data_o(f_ic_data), .ic_ready_o(f_ic_ready), .ic_err_o(f_ic_err),
        .dc_addr_i(f_dc_addr), .dc_valid_req_i(f_dc_valid),
        .dc_data_o(f_dc_data), .dc_ready_o(f_dc_ready), .dc_err_o(f_dc_err),
        .rom_addr_o(f_rom_addr), .rom_valid_req_o(f_rom_valid),
        .rom_data_i(f_rom_data), .rom_ready_i(f_rom_ready)
    );

    // ROM contents: byte at address b, little-endian within the line
    function automatic logic [127:0] rom_line(input logic [31:0] a);
        logic [127:0] r;
        logic [31:0]  b;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            b = a + 32'(i);
            r[8*i +: 8] = b[7:0] ^ b[11:4];
        end
        return r;
    endfunction

    int          rom_extra = 0;
    logic        pend = 1'b0;
    int          pcnt = 0;
    logic [31:0] paddr = '0;

    always @(posedge clk) begin
        rom_ready <= 1'b0;
        if (rom_valid) begin
            if (rom_extra == 0) begin
                rom_ready <= 1'b1;
                rom_data  <= rom_line(rom_addr);
            end else begin
                pend  <= 1'b1;
                pcnt  <= rom_extra - 1;
                paddr <= rom_addr;
            end
        end else if (pend) begin
            if (pcnt == 0) begin
                rom_ready <= 1'b1;
                rom_data  <= rom_line(paddr);
                pend      <= 1'b0;
            end else begin
                pcnt <= pcnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        f_rom_ready <= f_rom_valid;
        if (f_rom_valid) f_rom_data <= rom_line(f_rom_addr);
    end

    // completion / request counters and grant order of the round-robin instance
    int ic_cnt = 0, dc_cnt = 0, rq_cnt = 0, f_ic_cnt = 0, f_dc_cnt = 0, n_ord = 0;
    logic ord [0:63];
    always @(posedge clk) begin
        if (ic_ready) ic_cnt <= ic_cnt + 1;
        if (dc_ready) dc_cnt <= dc_cnt + 1;
        if (rom_valid) rq_cnt <= rq_cnt + 1;
        if (f_ic_ready) f_ic_cnt <= f_ic_cnt + 1;
        if (f_dc_ready) f_dc_cnt <= f_dc_cnt + 1;
        if ((ic_ready || dc_ready) && n_ord < 64) begin
            ord[n_ord] <= dc_ready;
            n_ord      <= n_ord + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    int b_ic, b_dc, b_rq, b_fic, b_fdc, b_ord;

    initial begin
        // reset state
        @(negedge clk);
        chk1("rst_ic_ready", ic_ready, 1'b0);
        chk1("rst_dc_ready", dc_ready, 1'b0);
        chk1("rst_rom_valid", rom_valid, 1'b0);
        chk32("rst_rom_addr", rom_addr, 32'h0);
        chk128("rst_ic_data", ic_data, 128'h0);
        chk1("rst_dc_err", dc_err, 1'b0);
        chk32("rst_state", 32'(dut.state), 32'(IDLE));
        rst_n = 1'b1;
        cyc();

        // single Icache request; cycle 0 is this half-cycle
        ic_addr = 32'h0000_0104;
        ic_valid = 1'b1;
        chk1("s_c0_rom_valid", rom_valid, 1'b0);
        cyc();
        chk1("s_c1_rom_valid", rom_valid, 1'b1);
        chk32("s_c1_rom_addr", rom_addr, 32'h0000_0100);
        ic_addr = 32'h0000_0200;
        cyc();
        chk1("s_c2_rom_valid", rom_valid, 1'b0);
        chk1("s_c2_ic_ready", ic_ready, 1'b0);
        cyc();
        chk1("s_c3_ic_ready", ic_ready, 1'b1);
        chk128("s_c3_ic_data", ic_data, rom_line(32'h0000_0100));
        chk1("s_c3_ic_err", ic_err, 1'b0);
        chk1("s_c3_dc_ready", dc_ready, 1'b0);
        chk128("s_c3_dc_data", dc_data, 128'h0);
        ic_valid = 1'b0;
        cyc();
        chk1("s_c4_ic_ready", ic_ready, 1'b0);
        chk128("s_c4_ic_data", ic_data, 128'h0);
        cyc();

        // simultaneous requests from reset: IC first, then DC, each once
        do_reset();
        b_ic = ic_cnt; b_dc = dc_cnt;
        ic_addr = 32'h0000_0040; dc_addr = 32'h0000_00A8;
        ic_valid = 1'b1; dc_valid = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            cyc();
            if (c == 1) chk32("b_c1_rom_addr", rom_addr, 32'h0000_0040);
            if (c == 3) begin
                chk1("b_c3_ic_ready", ic_ready, 1'b1);
                chk1("b_c3_dc_ready", dc_ready, 1'b0);
                chk128("b_c3_ic_data", ic_data, rom_line(32'h0000_0040));
                ic_valid = 1'b0;
            end
            if (c == 5) chk32("b_c5_rom_addr", rom_addr, 32'h0000_00A0);
            if (c == 7) begin
                chk1("b_c7_dc_ready", dc_ready, 1'b1);
                chk1("b_c7_ic_ready", ic_ready, 1'b0);
                chk128("b_c7_dc_data", dc_data, rom_line(32'h0000_00A0));
                dc_valid = 1'b0;
            end
        end
        chk32("b_ic_count", 32'(ic_cnt - b_ic), 32'd1);
        chk32("b_dc_count", 32'(dc_cnt - b_dc), 32'd1);

        // IC keeps requesting while DC waits: RR alternates, fixed starves DC
        do_reset();
        b_ic = ic_cnt; b_dc = dc_cnt; b_fic = f_ic_cnt; b_fdc = f_dc_cnt; b_ord = n_ord;
        ic_addr = 32'h10; dc_addr = 32'h20; f_ic_addr = 32'h30; f_dc_addr = 32'h50;
        ic_valid = 1'b1; dc_valid = 1'b1; f_ic_valid = 1'b1; f_dc_valid = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            cyc();
            if (dc_ready) dc_valid = 1'b0;
            if (f_dc_ready) f_dc_valid = 1'b0;
        end
        ic_valid = 1'b0; dc_valid = 1'b0; f_ic_valid = 1'b0; f_dc_valid = 1'b0;
        cyc();
        chk1("rr_grant0", ord[b_ord], REQ_IC);
        chk1("rr_grant1", ord[b_ord+1], REQ_DC);
        chk1("rr_grant2", ord[b_ord+2], REQ_IC);
        chk32("rr_ic_count", 32'(ic_cnt - b_ic), 32'd3);
        chk32("rr_dc_count", 32'(dc_cnt - b_dc), 32'd1);
        chk32("fp_ic_count", 32'(f_ic_cnt - b_fic), 32'd4);
        chk32("fp_dc_count", 32'(f_dc_cnt - b_fdc), 32'd0);
        cyc(); cyc(); cyc();

        // out of range: 0x1000 and a high address, no ROM access
        b_rq = rq_cnt;
        dc_addr = 32'h0000_1000;
        dc_valid = 1'b1;
        cyc();
        chk1("o_c1_rom_valid", rom_valid, 1'b0);
        chk1("o_c1_dc_ready", dc_ready, 1'b0);
        cyc();
        chk1("o_c2_dc_ready", dc_ready, 1'b1);
        chk1("o_c2_dc_err", dc_err, 1'b1);
        chk128("o_c2_dc_data", dc_data, 128'h0);
        chk1("o_c2_ic_ready", ic_ready, 1'b0);
        // asynchronous reset clears the pulse at once
        rst_n = 1'b0;
        #1;
        chk1("o_async_dc_ready", dc_ready, 1'b0);
        chk1("o_async_dc_err", dc_err, 1'b0);
        dc_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        ic_addr = 32'h8000_0100;
        ic_valid = 1'b1;
        cyc(); cyc();
        chk1("o_hi_ic_ready", ic_ready, 1'b1);
        chk1("o_hi_ic_err", ic_err, 1'b1);
        ic_valid = 1'b0;
        cyc();
        chk32("o_no_rom_req", 32'(rq_cnt - b_rq), 32'd0);
        // last in-range line
        ic_addr = 32'h0000_0FFC;
        ic_valid = 1'b1;
        cyc();
        chk1("o_edge_rom_valid", rom_valid, 1'b1);
        chk32("o_edge_rom_addr", rom_addr, 32'h0000_0FF0);
        cyc(); cyc();
        chk1("o_edge_ic_ready", ic_ready, 1'b1);
        chk1("o_edge_ic_err", ic_err, 1'b0);
        chk128("o_edge_ic_data", ic_data, rom_line(32'h0000_0FF0));
        ic_valid = 1'b0;
        cyc();

        // reset in WAIT: no stale ready, no further ROM request
        rom_extra = 3;
        b_ic = ic_cnt;
        ic_addr = 32'h0000_0020;
        ic_valid = 1'b1;
        cyc();
        chk1("w_c1_rom_valid", rom_valid, 1'b1);
        cyc();
        rst_n = 1'b0;
        #1;
        chk32("w_rst_state", 32'(dut.state), 32'(IDLE));
        chk1("w_rst_ic_ready", ic_ready, 1'b0);
        chk1("w_rst_rom_valid", rom_valid, 1'b0);
        ic_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        b_rq = rq_cnt;
        for (int c = 0; c < 8; c++) cyc();
        chk32("w_no_ready", 32'(ic_cnt - b_ic), 32'd0);
        chk32("w_no_rom_req", 32'(rq_cnt - b_rq), 32'd0);
        chk32("w_state_idle", 32'(dut.state), 32'(IDLE));

        // slow ROM: 3 extra cycles of WAIT
        ic_addr = 32'h0000_03F4;
        ic_valid = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            if (c >= 2 && c <= 5) chk1("sl_early_ready", ic_ready, 1'b0);
            if (c == 6) begin
                chk1("sl_c6_ic_ready", ic_ready, 1'b1);
                chk128("sl_c6_ic_data", ic_data, rom_line(32'h0000_03F0));
                ic_valid = 1'b0;
            end
        end
        cyc();
        chk1("sl_c7_ic_ready", ic_ready, 1'b0);
        rom_extra = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
